// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60Hz raster timing constants shared by the sync generator and drawing logic.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Contents: CNT_W / cnt_t (10-bit counter type), H_* / V_* active, porch, sync and total values,
//           derived sync window bounds, in_range() half-open window test.
package vga_timing_pkg;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t H_ACTIVE = 10'd640;
   localparam cnt_t H_FP     = 10'd16;
   localparam cnt_t H_SYNC   = 10'd96;
   localparam cnt_t H_BP     = 10'd48;
   localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

   localparam cnt_t V_ACTIVE = 10'd480;
   localparam cnt_t V_FP     = 10'd10;
   localparam cnt_t V_SYNC   = 10'd2;
   localparam cnt_t V_BP     = 10'd33;
   localparam cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

   // Sync windows are half-open: [start, end)
   localparam cnt_t H_SYNC_START = H_ACTIVE + H_FP;               // 656
   localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;         // 752
   localparam cnt_t V_SYNC_START = V_ACTIVE + V_FP;               // 490
   localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;         // 492

   function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: 10-bit counter 0..TERM, advancing when en is high and wrapping to 0 after TERM.
// Latency: count updates 1 clk after en; count_nxt and wrap are combinational views of the next edge.
// Backpressure: none; en is the only advance control.
// Ports: clk, reset (sync, active-high), en, count (registered), count_nxt (value after next edge),
//        wrap (1 on the cycle whose edge takes count from TERM back to 0).
module vga_wrap_counter
   import vga_timing_pkg::*;
#(
   parameter cnt_t TERM = 10'd1023
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output cnt_t count,
   output cnt_t count_nxt,
   output logic wrap
);

   always_comb begin
      wrap      = en && (count == TERM);
      count_nxt = count;
      if (wrap)
         count_nxt = '0;
      else if (en)
         count_nxt = count + cnt_t'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA 640x480@60Hz raster counters, h/v sync and display-enable from a 25 MHz pixel clock.
// Latency: every output is a flop; syncs/enable are decoded from next-state counters, so zero skew to X/Y.
// Backpressure: none; free-running raster.
// Ports: clk, reset (sync, active-high), vga_h_sync, vga_v_sync, inDisplayArea, CounterX[9:0], CounterY[9:0].
// Build option: HVSYNC_ACTIVE_HIGH_EN makes both syncs active-high (reset value 0); default is active-low.
module vga_sync_timing
   import vga_timing_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       inDisplayArea,
   output logic [9:0] CounterX,
   output logic [9:0] CounterY
);

`ifdef HVSYNC_ACTIVE_HIGH_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif

   cnt_t x_cnt, x_nxt, y_cnt, y_nxt;
   logic x_wrap, y_wrap;
   logic run;

   // The raster holds at (0,0) for the first edge after reset so that the first
   // post-reset cycle presents X=0,Y=0 with the enable/sync flops already decoded
   // for that position (inDisplayArea=1), instead of skipping pixel 0.
   vga_wrap_counter #(.TERM(H_TOTAL - 10'd1)) u_h_cnt (
      .clk       (clk),
      .reset     (reset),
      .en        (run),
      .count     (x_cnt),
      .count_nxt (x_nxt),
      .wrap      (x_wrap)
   );

   vga_wrap_counter #(.TERM(V_TOTAL - 10'd1)) u_v_cnt (
      .clk       (clk),
      .reset     (reset),
      .en        (x_wrap),
      .count     (y_cnt),
      .count_nxt (y_nxt),
      .wrap      (y_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         run           <= 1'b0;
         vga_h_sync    <= ~SYNC_ON;
         vga_v_sync    <= ~SYNC_ON;
         inDisplayArea <= 1'b0;
      end else begin
         run           <= 1'b1;
         vga_h_sync    <= in_range(x_nxt, H_SYNC_START, H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
         vga_v_sync    <= in_range(y_nxt, V_SYNC_START, V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
         inDisplayArea <= (x_nxt < H_ACTIVE) && (y_nxt < V_ACTIVE);
      end
   end

   assign CounterX = x_cnt;
   assign CounterY = y_cnt;

   // Frame wrap is implied by the counters themselves; nothing downstream needs it.
   logic unused_y_wrap;
   assign unused_y_wrap = y_wrap;

endmodule

// File: tb/tb_vga_sync_timing.sv
// tb_vga_sync_timing: directed bench for vga_sync_timing with a reference raster position model.
// Latency: n/a.  Backpressure: n/a.
// Ports: none (top-level bench); honours HVSYNC_ACTIVE_HIGH_EN for the expected sync polarity.
module tb_vga_sync_timing;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vga_h_sync, vga_v_sync, inDisplayArea;
   logic [9:0] CounterX, CounterY;

`ifdef HVSYNC_ACTIVE_HIGH_EN
   localparam int ON = 1;
`else
   localparam int ON = 0;
`endif
   localparam int OFF = 1 - ON;

   int n_checks = 0;
   int n_err    = 0;
   int mx = 0, my = 0;
   int xy_bad = 0, hs_bad = 0, vs_bad = 0, ide_bad = 0;
   int hs_cnt = 0, vs_cnt = 0, ide_late = 0;

   vga_sync_timing dut (
      .clk           (clk),
      .reset         (reset),
      .vga_h_sync    (vga_h_sync),
      .vga_v_sync    (vga_v_sync),
      .inDisplayArea (inDisplayArea),
      .CounterX      (CounterX),
      .CounterY      (CounterY)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Advance n clocks, moving the model along and tallying every per-cycle disagreement.
   task automatic run_chk(input int n);
      int hs_e, vs_e, ide_e;
      for (int i = 0; i < n; i++) begin
         step();
         if (mx == 799) begin
            mx = 0;
            my = (my == 524) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
         hs_e  = (mx >= 656 && mx <= 751) ? ON : OFF;
         vs_e  = (my == 490 || my == 491) ? ON : OFF;
         ide_e = (mx < 640 && my < 480) ? 1 : 0;
         if (int'(CounterX) != mx || int'(CounterY) != my) xy_bad++;
         if (int'(vga_h_sync) != hs_e) hs_bad++;
         if (int'(vga_v_sync) != vs_e) vs_bad++;
         if (int'(inDisplayArea) != ide_e) ide_bad++;
         if (int'(vga_h_sync) == ON) hs_cnt++;
         if (int'(vga_v_sync) == ON) vs_cnt++;
         if (my >= 480 && inDisplayArea) ide_late++;
      end
   endtask

   initial begin
      // Reset held for 3 clocks
      reset = 1'b1;
      repeat (3) step();
      chk("rst_x",   int'(CounterX), 0);
      chk("rst_y",   int'(CounterY), 0);
      chk("rst_ide", int'(inDisplayArea), 0);
      chk("rst_hs",  int'(vga_h_sync), OFF);
      chk("rst_vs",  int'(vga_v_sync), OFF);

      // First post-reset cycle: origin with display enable already high
      reset = 1'b0;
      step();
      chk("post_x",   int'(CounterX), 0);
      chk("post_y",   int'(CounterY), 0);
      chk("post_ide", int'(inDisplayArea), 1);
      chk("post_hs",  int'(vga_h_sync), OFF);
      chk("post_vs",  int'(vga_v_sync), OFF);
      mx = 0; my = 0;
      run_chk(1);
      chk("post_x1", int'(CounterX), 1);

      // Display-enable edge at X=640
      run_chk(638);
      chk("x639",     int'(CounterX), 639);
      chk("ide_639",  int'(inDisplayArea), 1);
      run_chk(1);
      chk("x640",     int'(CounterX), 640);
      chk("ide_640",  int'(inDisplayArea), 0);

      // Horizontal sync window 656..751
      run_chk(15);
      chk("hs_655", int'(vga_h_sync), OFF);
      run_chk(1);
      chk("hs_656", int'(vga_h_sync), ON);
      run_chk(95);
      chk("x751",   int'(CounterX), 751);
      chk("hs_751", int'(vga_h_sync), ON);
      run_chk(1);
      chk("hs_752", int'(vga_h_sync), OFF);

      // Line wrap: X 799->0 and Y 0->1 on the same edge
      run_chk(47);
      chk("x799",     int'(CounterX), 799);
      chk("y_line0",  int'(CounterY), 0);
      run_chk(1);
      chk("wrap_x",   int'(CounterX), 0);
      chk("wrap_y",   int'(CounterY), 1);

      // One full line: exactly 96 sync clocks
      hs_cnt = 0;
      run_chk(800);
      chk("hs_width", hs_cnt, 96);

      // Up to the last line before vertical sync
      run_chk(487 * 800 + 799);
      chk("y489",   int'(CounterY), 489);
      chk("vs_489", int'(vga_v_sync), OFF);
      vs_cnt = 0;
      ide_late = 0;
      run_chk(1);
      chk("y490",   int'(CounterY), 490);
      chk("vs_490", int'(vga_v_sync), ON);

      // Rest of the frame
      run_chk(34 * 800 + 799);
      chk("x799_end", int'(CounterX), 799);
      chk("y524",     int'(CounterY), 524);
      chk("vs_width", vs_cnt, 1600);
      chk("ide_blank", ide_late, 0);
      run_chk(1);
      chk("frame_x",   int'(CounterX), 0);
      chk("frame_y",   int'(CounterY), 0);
      chk("frame_ide", int'(inDisplayArea), 1);

      // Mid-frame reset at (300,200)
      run_chk(200 * 800 + 300);
      chk("mid_x", int'(CounterX), 300);
      chk("mid_y", int'(CounterY), 200);
      reset = 1'b1;
      step();
      chk("mrst_x",   int'(CounterX), 0);
      chk("mrst_y",   int'(CounterY), 0);
      chk("mrst_ide", int'(inDisplayArea), 0);
      chk("mrst_hs",  int'(vga_h_sync), OFF);
      chk("mrst_vs",  int'(vga_v_sync), OFF);
      reset = 1'b0;
      step();
      chk("mpost_x",   int'(CounterX), 0);
      chk("mpost_y",   int'(CounterY), 0);
      chk("mpost_ide", int'(inDisplayArea), 1);
      mx = 0; my = 0;
      run_chk(1);
      chk("mpost_x1", int'(CounterX), 1);

      // Per-cycle tallies across everything above
      chk("xy_track",  xy_bad, 0);
      chk("hs_track",  hs_bad, 0);
      chk("vs_track",  vs_bad, 0);
      chk("ide_track", ide_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
